// File: rtl/serial_write_buffer.sv
// Parallel-in, serial-out transmit buffer: latches a word on start and shifts it out one bit per write_sig.
// Optional macro SERIAL_WRITE_LSB_FIRST_EN selects LSB-first ordering (default MSB-first).
module serial_write_buffer #(
    parameter int   BUF_SIZE   = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                write_sig,
    input  logic [BUF_SIZE-1:0] data_in,
    output logic                data_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(BUF_SIZE + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BUF_SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [BUF_SIZE-1:0] shift_reg, shift_reg_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                data_out_n, busy_n, done_n;

    // NOTE: every next-value gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_n     = state;
        shift_reg_n = shift_reg;
        cnt_n       = cnt;
        data_out_n  = data_out;
        busy_n      = busy;
        done_n      = 1'b0;

        unique case (state)
            IDLE: begin
                // write_sig is ignored here, so a coincident strobe cannot shorten the first bit.
                if (start) begin
                    state_n     = SHIFT;
                    shift_reg_n = data_in;
                    cnt_n       = '0;
                    busy_n      = 1'b1;
`ifdef SERIAL_WRITE_LSB_FIRST_EN
                    data_out_n  = data_in[0];
`else
                    data_out_n  = data_in[BUF_SIZE-1];
`endif
                end
            end
            SHIFT: begin
                if (write_sig) begin
                    if (cnt == LAST_BIT) begin
                        state_n    = IDLE;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        data_out_n = IDLE_LEVEL;
                    end else begin
                        cnt_n       = cnt + 1'b1;
`ifdef SERIAL_WRITE_LSB_FIRST_EN
                        shift_reg_n = {1'b0, shift_reg[BUF_SIZE-1:1]};
                        data_out_n  = shift_reg[1];
`else
                        shift_reg_n = {shift_reg[BUF_SIZE-2:0], 1'b0};
                        data_out_n  = shift_reg[BUF_SIZE-2];
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            data_out  <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_reg_n;
            cnt       <= cnt_n;
            data_out  <= data_out_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_write_buffer.sv
// Directed self-checking bench for serial_write_buffer; expected bit order follows SERIAL_WRITE_LSB_FIRST_EN.
module tb_serial_write_buffer;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       start;
    logic       write_sig;
    logic [7:0] data_in;
    logic       data_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    serial_write_buffer #(.BUF_SIZE(8), .IDLE_LEVEL(1'b0)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .start    (start),
        .write_sig(write_sig),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse();
        write_sig = 1'b1;
        step();
        write_sig = 1'b0;
    endtask

    task automatic start_word(input logic [7:0] d);
        data_in = d;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Hand-written bit sequences: index i is the bit on the line during period i.
    function automatic logic exp_bit(input logic [7:0] seq, input int i);
        return seq[7-i];
    endfunction

    // Checks the 8 bit periods of a word already started, optionally injecting a start mid-word.
    task automatic run_word(input string tag, input logic [7:0] seq, input int gap,
                            input int restart_at, input logic [7:0] restart_data,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_bit"}, {7'd0, data_out}, {7'd0, exp_bit(seq, i)});
            check({tag, "_busy"}, {7'd0, busy}, 8'd1);
            check({tag, "_nodone"}, {7'd0, done}, 8'd0);
            if (i == restart_at) begin
                start_word(restart_data);
                check({tag, "_restart_ignored"}, {7'd0, data_out}, {7'd0, exp_bit(seq, i)});
            end
            for (int g = 0; g < gap; g++) step();
            check({tag, "_hold"}, {7'd0, data_out}, {7'd0, exp_bit(seq, i)});
`ifdef SERIAL_WRITE_LSB_FIRST_EN
            rx = {data_out, rx[7:1]};
`else
            rx = {rx[6:0], data_out};
`endif
            pulse();
        end
        check({tag, "_end_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_end_done"}, {7'd0, done}, 8'd1);
        check({tag, "_end_idle"}, {7'd0, data_out}, 8'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] seq_3a, seq_f0, seq_71, seq_a5;
`ifdef SERIAL_WRITE_LSB_FIRST_EN
        seq_3a = 8'b0101_1100;
        seq_f0 = 8'b0000_1111;
        seq_71 = 8'b1000_1110;
        seq_a5 = 8'b1010_0101;
`else
        seq_3a = 8'b0011_1010;
        seq_f0 = 8'b1111_0000;
        seq_71 = 8'b0111_0001;
        seq_a5 = 8'b1010_0101;
`endif
        rst = 1'b1; start = 1'b0; write_sig = 1'b0; data_in = 8'h00;
        #2;
        check("reset_data_out", {7'd0, data_out}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        step(); step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 20; i++) pulse();
        check("idle_pulses_data_out", {7'd0, data_out}, 8'd0);
        check("idle_pulses_busy", {7'd0, busy}, 8'd0);
        check("idle_pulses_done", {7'd0, done}, 8'd0);

        // Basic word with 8-clock bit periods.
        start_word(8'h3a);
        run_word("basic", seq_3a, 7, -1, 8'h00, rx);
        step();
        check("basic_done_one_cycle", {7'd0, done}, 8'd0);
        check("basic_rx", rx, 8'h3a);

        // Loopback through a bench-side receiver that samples before each strobe.
        step(); step();
        start_word(8'h71);
        run_word("loop", seq_71, 3, -1, 8'h00, rx);
        check("loop_rx", rx, 8'h71);

        // Back-to-back: start while done is high is accepted.
        start_word(8'ha5);
        check("b2b_busy", {7'd0, busy}, 8'd1);
        run_word("b2b", seq_a5, 1, -1, 8'h00, rx);
        check("b2b_rx", rx, 8'ha5);
        step();

        // Start while busy is ignored.
        start_word(8'hf0);
        run_word("busy_start", seq_f0, 2, 3, 8'h0f, rx);
        step();
        check("busy_start_done_once", {7'd0, done}, 8'd0);
        check("busy_start_rx", rx, 8'hf0);

        // Start coincident with the terminating strobe is ignored.
        start_word(8'h3a);
        for (int i = 0; i < 7; i++) pulse();
        data_in = 8'hff; start = 1'b1; write_sig = 1'b1;
        step();
        start = 1'b0; write_sig = 1'b0;
        check("term_start_busy", {7'd0, busy}, 8'd0);
        check("term_start_done", {7'd0, done}, 8'd1);
        step();
        check("term_start_still_idle", {7'd0, busy}, 8'd0);
        check("term_start_data_out", {7'd0, data_out}, 8'd0);

        // Start and write_sig together in IDLE: MSB still gets a full period.
        data_in = 8'h3a; start = 1'b1; write_sig = 1'b1;
        step();
        start = 1'b0; write_sig = 1'b0;
        run_word("start_ws", seq_3a, 1, -1, 8'h00, rx);
        check("start_ws_rx", rx, 8'h3a);
        step();

        // Reset mid-word.
        start_word(8'hff);
        for (int i = 0; i < 4; i++) pulse();
        check("mid_pre_busy", {7'd0, busy}, 8'd1);
        check("mid_pre_bit", {7'd0, data_out}, 8'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_data_out", {7'd0, data_out}, 8'd0);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_done", {7'd0, done}, 8'd0);
        step();
        rst = 1'b0;
        step();
        check("mid_post_done", {7'd0, done}, 8'd0);
        start_word(8'h3a);
        run_word("post_rst", seq_3a, 2, -1, 8'h00, rx);
        check("post_rst_rx", rx, 8'h3a);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_write_buffer.md
Name: serial_write_buffer

Overview:
- Transmit-side counterpart of the serial read buffer: parallel-in, serial-out shift register.
- Latches a BUF_SIZE-bit word on `start` and drives it MSB-first on one serial line.
- Advances one bit per single-cycle `write_sig` strobe; `write_sig` is typically an edge-detector pulse generated from the bus clock on the edge opposite to the receiver's sampling edge.
- Sits between the MITM core logic and the output pin of a proxied serial bus.

Parameters:
- BUF_SIZE, 8: word width in bits; must be >= 2.
- IDLE_LEVEL, 1'b0: level driven on `data_out` when not transmitting.

Ports:
- sys_clk  input  1  system clock; all logic rising-edge triggered.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to load `data_in` and begin transmission.
- write_sig  input  1  single-cycle strobe; ends the current bit period.
- data_in  input  BUF_SIZE  parallel word, sampled only on an accepted `start`.
- data_out  output  1  serial output, registered.
- busy  output  1  high while a word is being shifted out.
- done  output  1  single-cycle pulse when the last bit period ends.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, `busy`=0, `done`=0, `data_out`=IDLE_LEVEL, shift register 0, bit counter 0.
- Two states: IDLE and SHIFT. Bit counter width is $clog2(BUF_SIZE+1).
- IDLE:
  - On `start`=1 at edge N: shift_reg <= data_in, counter <= 0, state <= SHIFT.
  - Cycle N+1: `busy`=1 and `data_out`=data_in[BUF_SIZE-1].
  - `write_sig` in IDLE is ignored.
- SHIFT, on each `write_sig` pulse:
  - If counter < BUF_SIZE-1: shift left by one, counter++, and `data_out` shows the next lower bit one cycle after the pulse.
  - If counter == BUF_SIZE-1 (last bit period ends): state <= IDLE, `busy` <= 0, `done` <= 1 for exactly one cycle, `data_out` <= IDLE_LEVEL.
- Counts: BUF_SIZE-1 `write_sig` pulses produce bit transitions; the BUF_SIZE-th pulse terminates the word.
- Cycles without `write_sig` hold all state and `data_out` stable.
- `start` while `busy`=1 is ignored; the word in flight is not corrupted and `data_in` is not resampled.
- `start` and `write_sig` in the same cycle in IDLE: start is accepted, write_sig is ignored, so bit MSB gets a full period.
- Back-to-back words:
  - `start` in the same cycle `done` is high is accepted.
  - `start` in the cycle of the terminating `write_sig` is ignored, because state is still SHIFT at that edge.
- Reset mid-word: everything returns to reset values at once; the partial word is discarded and `done` is not asserted.
- `data_out`, `busy` and `done` are all register outputs, with no combinational path from any input.

Optional Feature:
- Macro: SERIAL_WRITE_LSB_FIRST_EN.
- Defined: bit order is LSB first. The first bit driven is data_in[0], the register shifts right, and the terminating rule is unchanged.
- Undefined: MSB first as described above, matching the read buffer's default ordering.

Test Plan:
- Reset then idle: assert rst with no start → `data_out`=IDLE_LEVEL, `busy`=0, `done`=0; 20 `write_sig` pulses produce no change.
- Basic word: start with data_in=8'h3a, then 8 write_sig pulses spaced 8 clocks apart → `data_out` sequence 0,0,1,1,1,0,1,0, one bit per period. `busy` falls and `done` pulses for 1 cycle after the 8th pulse.
- Loopback: connect `data_out` to the serial read buffer, share the bus clock (read on rising edge, write on falling edge), send 8'h71 → the read buffer yields `data_out`=8'h71 with `data_ready`.
- Start while busy: start 8'hf0, then after 3 pulses start again with data_in=8'h0f → the line still completes 1,1,1,1,0,0,0,0 and `done` pulses exactly once.
- Reset mid-word: start 8'hff, apply a 1-cycle rst after 4 pulses → `data_out`=IDLE_LEVEL and `busy`=0 immediately, no `done`. A following start of 8'h3a transmits correctly.
- Macro build: with SERIAL_WRITE_LSB_FIRST_EN defined, start 8'h3a → sequence 0,1,0,1,1,1,0,0.
